// File: rtl/main_1_pkg.sv
// main_1 shared types and helpers.
// Commutation table, duty clamp, widths.
package main_1_pkg;

  localparam int PWM_BITS = 8;
  localparam int SAT      = 511;

  typedef struct packed {
    logic a;
    logic aa;
    logic b;
    logic bb;
    logic c;
    logic cc;
  } drive_t;

  // Hall state to {A,AA,B,BB,C,CC}; 000/111 are invalid.
  function automatic drive_t commutate(input logic [2:0] h);
    drive_t d;
    d = '0;
    case (h)
      3'b100: d = 6'b100001;
      3'b101: d = 6'b100100;
      3'b001: d = 6'b000110;
      3'b011: d = 6'b010010;
      3'b010: d = 6'b011000;
      3'b110: d = 6'b001001;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Saturate the PD output into the duty range.
  function automatic logic [PWM_BITS-1:0] clamp_duty(
    input logic signed [16:0] u
  );
    logic [PWM_BITS-1:0] r;
    r = '0;
    unique case (1'b1)
      (u < 0):         r = '0;
      (u > 17'sd255):  r = '1;
      default:         r = u[PWM_BITS-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/main_1_pd.sv
// main_1 PD speed loop.
// Three-stage error, product/sum, clamp.
module pd_speed_ctrl
  import main_1_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8:0]          period,
  input  logic                pvalid,
  input  logic [3:0]          kp,
  input  logic [3:0]          kd,
  input  logic [8:0]          ticks,
  output logic [PWM_BITS-1:0] duty_next,
  output logic                dvalid
);

  logic signed [9:0]  e_c;
  logic signed [9:0]  e_r;
  logic signed [9:0]  e_prev;
  logic signed [10:0] de_c;
  logic signed [10:0] de_r;
  logic [3:0]         kp_r;
  logic [3:0]         kd_r;
  logic signed [16:0] pe;
  logic signed [16:0] pdv;
  logic signed [16:0] u_c;
  logic signed [16:0] u_r;
  logic               v1;
  logic               v2;

  assign e_c  = {1'b0, period} - {1'b0, ticks};
  assign de_c = {e_c[9], e_c} - {e_prev[9], e_prev};

  assign pe  = $signed({13'd0, kp_r})
             * $signed({{7{e_r[9]}}, e_r});
  assign pdv = $signed({13'd0, kd_r})
             * $signed({{6{de_r[10]}}, de_r});
  assign u_c = pe + pdv;

  // Stage 1: error terms and gain sample on a measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_r    <= '0;
      de_r   <= '0;
      e_prev <= '0;
      kp_r   <= '0;
      kd_r   <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= pvalid;
      if (pvalid) begin
        e_r    <= e_c;
        de_r   <= de_c;
        e_prev <= e_c;
        kp_r   <= kp;
        kd_r   <= kd;
      end
    end
  end

  // Stage 2: weighted sum of error and error slope.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_r <= '0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) u_r <= u_c;
    end
  end

  // Stage 3: clamp into the duty range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_next <= {1'b1, {(PWM_BITS-1){1'b0}}};
      dvalid    <= 1'b0;
    end else begin
      dvalid <= v2;
      if (v2) duty_next <= clamp_duty(u_r);
    end
  end

endmodule

// File: rtl/main_1.sv
// main_1 sensored BLDC controller top.
// Hall sync, six-step drive, period, PWM.
module main_1
  import main_1_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int SAT      = 511
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       H1,
  input  logic       H2,
  input  logic       H3,
  input  logic [3:0] Kp,
  input  logic [3:0] Kd,
  input  logic [8:0] Ticks,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       AA,
  output logic       BB,
  output logic       CC
);

  logic [2:0]          s1;
  logic [2:0]          hs;
  logic [2:0]          hs_prev;
  logic                chg;
  logic [8:0]          per_cnt;
  logic [8:0]          period;
  logic                pvalid;
  logic                seen;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_next;
  logic                dvalid;
  logic                dpend;
  logic                wrap;
  logic                pwm;
  drive_t              dv;
  drive_t              q;

  assign chg  = hs != hs_prev;
  assign wrap = &pwm_cnt;
  assign pwm  = pwm_cnt < duty;
  assign dv   = commutate(hs);

  // Two-flop Hall synchroniser plus previous-state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1      <= '0;
      hs      <= '0;
      hs_prev <= '0;
    end else begin
      s1      <= {H1, H2, H3};
      hs      <= s1;
      hs_prev <= hs;
    end
  end

  // Saturating edge-interval counter; first event only arms it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      per_cnt <= '0;
      period  <= '0;
      pvalid  <= 1'b0;
      seen    <= 1'b0;
    end else begin
      pvalid <= chg & seen;
      if (chg) begin
        seen    <= 1'b1;
        period  <= per_cnt;
        per_cnt <= 9'd1;
      end else if (per_cnt != 9'(SAT)) begin
        per_cnt <= per_cnt + 9'd1;
      end
    end
  end

  pd_speed_ctrl u_pd (
    .clk       (CLK),
    .rst_n     (RST_N),
    .period    (period),
    .pvalid    (pvalid),
    .kp        (Kp),
    .kd        (Kd),
    .ticks     (Ticks),
    .duty_next (duty_next),
    .dvalid    (dvalid)
  );

  // Free-running PWM counter; new duty taken only at wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt <= '0;
      duty    <= {1'b1, {(PWM_BITS-1){1'b0}}};
      dpend   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      dpend   <= dvalid | (dpend & ~wrap);
      if (wrap && dpend) duty <= duty_next;
    end
  end

  // Gate drive register; blank all six while the step changes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= '0;
    end else if (s1 != hs) begin
      q <= '0;
    end else begin
      q.a  <= dv.a & pwm;
      q.aa <= dv.aa;
      q.b  <= dv.b & pwm;
      q.bb <= dv.bb;
      q.c  <= dv.c & pwm;
      q.cc <= dv.cc;
    end
  end

  assign A  = q.a;
  assign AA = q.aa;
  assign B  = q.b;
  assign BB = q.bb;
  assign C  = q.c;
  assign CC = q.cc;

endmodule

// File: tb/tb_main_1.sv
// main_1 directed testbench.
// Commutation, PD duty, clamps, stall, shoot-through.
module tb_main_1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       H1, H2, H3;
  logic [3:0] Kp, Kd;
  logic [8:0] Ticks;
  logic       A, B, C, AA, BB, CC;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] LOWS = 6'b010101;

  always #10 CLK = ~CLK;

  main_1 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .H1    (H1),
    .H2    (H2),
    .H3    (H3),
    .Kp    (Kp),
    .Kd    (Kd),
    .Ticks (Ticks),
    .A     (A),
    .B     (B),
    .C     (C),
    .AA    (AA),
    .BB    (BB),
    .CC    (CC)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_drive(input logic [2:0] h);
    logic [5:0] d;
    case (h)
      3'b100: d = 6'b100001;
      3'b101: d = 6'b100100;
      3'b001: d = 6'b000110;
      3'b011: d = 6'b010010;
      3'b010: d = 6'b011000;
      3'b110: d = 6'b001001;
      default: d = 6'b000000;
    endcase
    return d;
  endfunction

  function automatic logic [5:0] outs();
    return {A, AA, B, BB, C, CC};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_h(input logic [2:0] h);
    {H1, H2, H3} = h;
  endtask

  task automatic do_reset(input logic [2:0] h);
    @(negedge CLK);
    RST_N = 1'b0;
    set_h(h);
    cyc(3);
    RST_N = 1'b1;
  endtask

  task automatic count_hi(input int n, output int hi,
                          output logic [5:0] orv,
                          output logic [5:0] andv);
    hi   = 0;
    orv  = '0;
    andv = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      hi   += int'(A) + int'(B) + int'(C);
      orv  |= outs();
      andv &= outs();
    end
  endtask

  task automatic run_pd(input logic [3:0] kp, input logic [3:0] kd,
                        input logic [8:0] tk, input int n,
                        output int hi);
    logic [2:0] seq [6] = '{3'b100, 3'b101, 3'b001,
                            3'b011, 3'b010, 3'b110};
    logic [5:0] o, a;
    Kp = kp;
    Kd = kd;
    Ticks = tk;
    do_reset(3'b000);
    cyc(2);
    for (int k = 0; k < n; k++) begin
      set_h(seq[k]);
      cyc(50);
    end
    cyc(300);
    count_hi(256, hi, o, a);
  endtask

  initial begin
    logic [2:0] sweep [6] = '{3'b101, 3'b001, 3'b011,
                              3'b010, 3'b110, 3'b100};
    logic [2:0] prev;
    logic [5:0] o, a;
    int hi;
    int viol;

    RST_N = 1'b0;
    Kp = 4'd3;
    Kd = 4'd4;
    Ticks = 9'd30;
    set_h(3'b100);
    cyc(3);
    chk("rst_outs", outs(), 0);
    RST_N = 1'b1;
    cyc(4);
    count_hi(256, hi, o, a);
    chk("rst_duty128", hi, 128);
    chk("rst_or", o, 6'b100001);
    chk("rst_lows", a & LOWS, 6'b000001);

    @(posedge CLK);
    #5 RST_N = 1'b0;
    #1 chk("async_rst", outs(), 0);

    Kp = 4'd15;
    Kd = 4'd0;
    Ticks = 9'd0;
    do_reset(3'b100);
    cyc(4);
    prev = 3'b100;
    foreach (sweep[i]) begin
      set_h(sweep[i]);
      @(negedge CLK);
      chk("lat_old", outs() & LOWS, exp_drive(prev) & LOWS);
      @(negedge CLK);
      chk("dead", outs(), 0);
      @(negedge CLK);
      chk("lat_new", outs() & LOWS, exp_drive(sweep[i]) & LOWS);
      count_hi(300, hi, o, a);
      chk("step_or", o, exp_drive(sweep[i]));
      chk("step_low", a & LOWS, exp_drive(sweep[i]) & LOWS);
      prev = sweep[i];
    end
    set_h(3'b000);
    cyc(3);
    count_hi(50, hi, o, a);
    chk("inv000", o, 0);
    set_h(3'b111);
    cyc(3);
    count_hi(50, hi, o, a);
    chk("inv111", o, 0);

    run_pd(4'd3, 4'd4, 9'd30, 2, hi);
    chk("pd_first", hi, 140);
    run_pd(4'd3, 4'd4, 9'd30, 3, hi);
    chk("pd_second", hi, 60);

    Kp = 4'd15;
    Ticks = 9'd0;
    cyc(1000);
    chk("stall_cnt", int'(dut.per_cnt), 511);
    count_hi(256, hi, o, a);
    chk("stall_duty", hi, 60);

    run_pd(4'd15, 4'd4, 9'd0, 2, hi);
    chk("clamp_hi", hi, 255);
    run_pd(4'd3, 4'd4, 9'd511, 2, hi);
    chk("clamp_lo", hi, 0);

    viol = 0;
    do_reset(3'b100);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        set_h(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) begin
        Kp = 4'($urandom_range(0, 15));
        Kd = 4'($urandom_range(0, 15));
        Ticks = 9'($urandom_range(0, 511));
      end
      @(negedge CLK);
      if ((A & AA) | (B & BB) | (C & CC)) viol++;
    end
    chk("shoot", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
